tm_bram_stream_reader: RTL and testbench

- Parametrised BRAM-port-B streaming reader for the Tsetlin inference path.
- Walks a packed record buffer from a programmable base address and decodes each word into feature/class/clause fields.
- Hands decoded records to the inference core over a valid/ready handshake.
- Honours STALL and END sentinel words; reports done/overrun/timeout status.

---
 rtl/tm_bram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_tm_bram_stream_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_bram_stream_reader.sv
// Purpose: BRAM port-B record streamer for Tsetlin inference; optional result writeback under TM_RESULT_WRITEBACK_EN.
// Latency: BRAM_LAT+1 cycles from read issue to decode; beat_valid rises the cycle after decode.
// Backpressure: a beat is held stable until beat_ready; no further read is issued while a beat is pending.
module tm_bram_stream_reader #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                FEAT_W     = 8,
    parameter int                CLASS_W    = 4,
    parameter int                CLAUSE_W   = 9,
    parameter int                BRAM_LAT   = 1,
    parameter logic [DATA_W-1:0] STALL_WORD = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0] END_WORD   = 32'hFFFF_FF00,
    parameter int                POLL_GAP   = 4,
    parameter int                POLL_LIMIT = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           max_words,
`ifdef TM_RESULT_WRITEBACK_EN
    input  logic [DATA_W-1:0]     result_word,
`endif
    output logic [ADDR_W-1:0]     bram_addr,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [FEAT_W-1:0]     beat_feature,
    output logic [CLASS_W-1:0]    beat_class,
    output logic [CLAUSE_W-1:0]   beat_clause,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overrun,
    output logic                  err_timeout,
    output logic [15:0]           word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_HOLD, S_POLL, S_FIN
`ifdef TM_RESULT_WRITEBACK_EN
        , S_WB
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W / 8);
    localparam logic [15:0]       LAT_LAST = 16'(BRAM_LAT - 1);
    // The EVAL cycle already counts as the first idle cycle of the re-poll gap.
    localparam int                POLL_CYC  = (POLL_GAP > 1) ? POLL_GAP - 1 : 1;
    localparam logic [15:0]       POLL_LAST = 16'(POLL_CYC - 1);
    localparam logic [15:0]       POLL_MAX  = 16'(POLL_LIMIT);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       budget;
    logic [15:0]       poll_cnt;
    logic [15:0]       cnt;
    logic [DATA_W-1:0] rec;
    logic              is_end, is_stall, timed_out, last_beat;

    assign is_end    = (rec == END_WORD);
    assign is_stall  = (rec == STALL_WORD);
    assign timed_out = (POLL_LIMIT != 0) && (poll_cnt == POLL_MAX);
    assign last_beat = ((word_count + 16'd1) == budget);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (cnt == LAT_LAST) state_n = S_EVAL;
            S_EVAL: begin
`ifdef TM_RESULT_WRITEBACK_EN
                if (is_end)        state_n = S_WB;
`else
                if (is_end)        state_n = S_FIN;
`endif
                else if (is_stall) state_n = timed_out ? S_FIN : S_POLL;
                else               state_n = S_HOLD;
            end
            S_HOLD:  if (beat_ready) state_n = last_beat ? S_FIN : S_ISSUE;
            S_POLL:  if (cnt == POLL_LAST) state_n = S_ISSUE;
            S_FIN:   state_n = S_IDLE;
`ifdef TM_RESULT_WRITEBACK_EN
            S_WB:    state_n = S_FIN;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr        <= '0;
            budget      <= '0;
            poll_cnt    <= '0;
            cnt         <= '0;
            rec         <= '0;
            word_count  <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // cnt measures time spent in the current state (WAIT and POLL use it).
            cnt <= (state_n != state) ? 16'd0 : cnt + 16'd1;
            case (state)
                S_IDLE: if (start) begin
                    addr        <= base_addr;
                    budget      <= (max_words == 16'd0) ? 16'd1 : max_words;
                    word_count  <= '0;
                    poll_cnt    <= '0;
                    err_overrun <= 1'b0;
                    err_timeout <= 1'b0;
                end
                S_WAIT: if (cnt == LAT_LAST) rec <= bram_dout;
                S_EVAL: begin
                    if (!is_stall)      poll_cnt    <= '0;
                    else if (timed_out) err_timeout <= 1'b1;
                end
                S_HOLD: if (beat_ready) begin
                    word_count <= word_count + 16'd1;
                    addr       <= addr + STEP;
                    if (last_beat) err_overrun <= 1'b1;
                end
                S_POLL: if (cnt == POLL_LAST) poll_cnt <= poll_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FIN);
    assign beat_valid   = (state == S_HOLD);
    assign beat_feature = rec[FEAT_W-1:0];
    assign beat_class   = rec[DATA_W-1 -: CLASS_W];
    assign beat_clause  = rec[DATA_W-1-CLASS_W -: CLAUSE_W];

`ifdef TM_RESULT_WRITEBACK_EN
    // Writeback lands one word past the END sentinel.
    assign bram_addr = (state == S_WB) ? addr + STEP : addr;
    assign bram_en   = (state == S_ISSUE) || (state == S_WB);
    assign bram_we   = {(DATA_W/8){state == S_WB}};
    assign bram_din  = (state == S_WB) ? result_word : '0;
`else
    assign bram_addr = addr;
    assign bram_en   = (state == S_ISSUE);
    assign bram_we   = '0;
    assign bram_din  = '0;
`endif

endmodule

// File: tb/tb_tm_bram_stream_reader.sv
// Bench for tm_bram_stream_reader: BRAM model with per-word stall counts, queue-based reference of reads, beats and final status.
module tb_tm_bram_stream_reader;

    localparam int          BRAM_LAT   = 1;
    localparam int          POLL_GAP   = 4;
    localparam int          POLL_LIMIT = 3;
    localparam logic [31:0] STALL_W    = 32'hFFFF_FFFF;
    localparam logic [31:0] END_W      = 32'hFFFF_FF00;

    logic        clock, reset_n, start;
    logic [31:0] base_addr;
    logic [15:0] max_words;
    logic [31:0] bram_addr, bram_din, bram_dout;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic        beat_valid, beat_ready;
    logic [7:0]  beat_feature;
    logic [3:0]  beat_class;
    logic [8:0]  beat_clause;
    logic        busy, done, err_overrun, err_timeout;
    logic [15:0] word_count;

    tm_bram_stream_reader #(
        .DATA_W(32), .ADDR_W(32), .FEAT_W(8), .CLASS_W(4), .CLAUSE_W(9),
        .BRAM_LAT(BRAM_LAT), .STALL_WORD(STALL_W), .END_WORD(END_W),
        .POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .max_words(max_words),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_feature(beat_feature), .beat_class(beat_class), .beat_clause(beat_clause),
        .busy(busy), .done(done), .err_overrun(err_overrun), .err_timeout(err_timeout),
        .word_count(word_count)
    );

    typedef struct {
        logic [7:0]  f;
        logic [3:0]  c;
        logic [8:0]  k;
        logic [31:0] a;
    } beat_t;

    logic [31:0] mem       [0:255];
    int          stall_cnt [0:255];
    int          rd_cnt    [0:255];

    logic [31:0] exp_rd[$];
    beat_t       exp_beats[$];
    int          exp_wc;
    bit          exp_ov, exp_to;
    logic [31:0] exp_addr;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    bit chk_en = 0;
    int ready_mode = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: observed %0h with nothing expected", name, act);
    endtask

    // BRAM: each word returns STALL for stall_cnt reads, then its data; counts reset per batch.
    always @(posedge clock) begin
        if (start && !busy) begin
            for (int i = 0; i < 256; i++) rd_cnt[i] <= 0;
        end else if (bram_en) begin
            if (rd_cnt[bram_addr[9:2]] < stall_cnt[bram_addr[9:2]]) begin
                bram_dout <= STALL_W;
                rd_cnt[bram_addr[9:2]] <= rd_cnt[bram_addr[9:2]] + 1;
            end else begin
                bram_dout <= mem[bram_addr[9:2]];
            end
        end
    end

    initial begin
        beat_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       beat_ready = 1'b1;
                1:       beat_ready = 1'($urandom_range(0, 1));
                default: beat_ready = 1'b0;
            endcase
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]       = END_W;
            stall_cnt[i] = 0;
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == STALL_W || w == END_W) w = w ^ 32'h1;
        return w;
    endfunction

    // Reference: walk the buffer word by word applying the batch rules directly.
    task automatic model_run(input logic [31:0] base, input logic [15:0] maxw);
        logic [31:0] a, w;
        int          budget, beats, s;
        bit          fin;
        beat_t       bt;
        exp_rd.delete();
        exp_beats.delete();
        budget = (maxw == 16'd0) ? 1 : int'(maxw);
        a = base; beats = 0; exp_ov = 0; exp_to = 0; fin = 0;
        while (!fin) begin
            s = stall_cnt[a[9:2]];
            if (POLL_LIMIT != 0 && s > POLL_LIMIT) begin
                for (int k = 0; k <= POLL_LIMIT; k++) exp_rd.push_back(a);
                exp_to = 1;
                fin = 1;
            end else begin
                for (int k = 0; k <= s; k++) exp_rd.push_back(a);
                w = mem[a[9:2]];
                if (w == END_W) begin
                    fin = 1;
                end else begin
                    bt.f = w[7:0]; bt.c = w[31:28]; bt.k = w[27:19]; bt.a = a;
                    exp_beats.push_back(bt);
                    beats++;
                    a = a + 32'd4;
                    if (beats == budget) begin
                        exp_ov = 1;
                        fin = 1;
                    end
                end
            end
        end
        exp_wc = beats;
        exp_addr = a;
    endtask

    initial begin : compare
        int          cyc;
        int          prev_cyc;
        bit          have_prev;
        logic [31:0] prev_a;
        beat_t       e;
        cyc = 0; prev_cyc = 0; have_prev = 0; prev_a = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (done) done_total++;
            if (!chk_en) begin
                have_prev = 0;
            end else begin
                chk("no_write", {bram_we, bram_din}, 64'd0);
                if (bram_en) begin
                    if (exp_rd.size() == 0) fail("rd_unexpected", bram_addr);
                    else chk("rd_addr", bram_addr, exp_rd.pop_front());
                    if (have_prev && bram_addr == prev_a)
                        chk("poll_gap", cyc - prev_cyc, POLL_GAP + BRAM_LAT + 1);
                    have_prev = 1; prev_a = bram_addr; prev_cyc = cyc;
                end
                if (beat_valid) begin
                    if (exp_beats.size() == 0) begin
                        fail("beat_unexpected", {beat_feature, beat_class, beat_clause});
                    end else begin
                        e = exp_beats[0];
                        chk("beat_fields", {beat_feature, beat_class, beat_clause}, {e.f, e.c, e.k});
                        chk("beat_addr", bram_addr, e.a);
                        if (beat_ready) void'(exp_beats.pop_front());
                    end
                end
                if (done) begin
                    chk("done_wc", word_count, exp_wc);
                    chk("done_ov", err_overrun, exp_ov);
                    chk("done_to", err_timeout, exp_to);
                    chk("done_addr", bram_addr, exp_addr);
                    chk("done_busy", busy, 1);
                    have_prev = 0;
                end
            end
        end
    end

    task automatic run_batch(input logic [31:0] base, input logic [15:0] maxw,
                             input int rmode, input bit hold_first);
        int n, d0;
        ready_mode = hold_first ? 2 : rmode;
        d0 = done_total;
        chk_en = 1;
        @(posedge clock); #1;
        base_addr = base; max_words = maxw; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (hold_first) begin
            n = 0;
            while (!beat_valid && n < 200) begin @(negedge clock); n++; end
            if (!beat_valid) fail("hold_wait_timeout", n);
            // A start pulse while busy must be ignored.
            @(posedge clock); #1;
            base_addr = 32'h200; max_words = 16'd1; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            repeat (3) @(posedge clock);
            ready_mode = rmode;
        end
        n = 0;
        while (done_total == d0 && n < 4000) begin @(posedge clock); n++; end
        if (done_total == d0) fail("done_timeout", n);
        repeat (4) @(posedge clock);
        #1;
        chk("done_once", done_total - d0, 1);
        chk("reads_left", exp_rd.size(), 0);
        chk("beats_left", exp_beats.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin : main
        int          n, d0, bidx, len, r;
        logic [15:0] mw;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; max_words = '0;
        clear_mem();
        #3;
        chk("rst_bram", {bram_en, bram_we, bram_addr}, 64'd0);
        chk("rst_din", bram_din, 0);
        chk("rst_beat", {beat_valid, beat_feature, beat_class, beat_clause}, 64'd0);
        chk("rst_stat", {busy, done, err_overrun, err_timeout, word_count}, 64'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Basic two-beat buffer.
        clear_mem();
        mem[64] = 32'h1280_0005; mem[65] = 32'h2100_00AA; mem[66] = END_W;
        model_run(32'h100, 16'd8);
        chk("model_b0", {exp_beats[0].f, exp_beats[0].c, exp_beats[0].k}, {8'h05, 4'h1, 9'h050});
        chk("model_b1", {exp_beats[1].f, exp_beats[1].c, exp_beats[1].k}, {8'hAA, 4'h2, 9'h020});
        chk("model_end", exp_addr, 32'h108);
        run_batch(32'h100, 16'd8, 0, 0);
        chk("t1_wc", word_count, 2);
        chk("t1_addr", bram_addr, 32'h108);
        chk("t1_err", {err_overrun, err_timeout}, 0);

        // Same buffer, first beat backpressured.
        model_run(32'h100, 16'd8);
        run_batch(32'h100, 16'd8, 0, 1);
        chk("t2_wc", word_count, 2);
        chk("t2_addr", bram_addr, 32'h108);

        // Word at 0x104 stalls for three re-reads, then resolves.
        stall_cnt[65] = 3;
        model_run(32'h100, 16'd8);
        chk("model_polls", exp_rd.size(), 6);
        run_batch(32'h100, 16'd8, 0, 0);
        chk("t3_wc", word_count, 2);

        // Permanent stall at 0x104 -> timeout.
        stall_cnt[65] = 100000;
        model_run(32'h100, 16'd8);
        run_batch(32'h100, 16'd8, 0, 0);
        chk("t4_wc", word_count, 1);
        chk("t4_to", {err_timeout, err_overrun}, 2'b10);
        chk("t4_addr", bram_addr, 32'h104);

        // Budget of 2 with no END -> overrun.
        clear_mem();
        for (int i = 64; i < 68; i++) mem[i] = rand_word();
        model_run(32'h100, 16'd2);
        run_batch(32'h100, 16'd2, 0, 0);
        chk("t5_ov", {err_overrun, err_timeout}, 2'b10);
        chk("t5_wc", word_count, 2);
        chk("t5_addr", bram_addr, 32'h108);

        // max_words of 0 behaves as 1.
        model_run(32'h100, 16'd0);
        run_batch(32'h100, 16'd0, 0, 0);
        chk("t6_wc", word_count, 1);
        chk("t6_ov", err_overrun, 1);

        // Address wraps past the top of the address space.
        clear_mem();
        mem[255] = 32'h3000_0077; mem[0] = END_W;
        model_run(32'hFFFF_FFFC, 16'd4);
        run_batch(32'hFFFF_FFFC, 16'd4, 0, 0);
        chk("t7_addr", bram_addr, 32'h0);
        chk("t7_wc", word_count, 1);

        // Randomized buffers, stalls, budgets and ready patterns.
        for (int b = 0; b < 14; b++) begin
            clear_mem();
            bidx = $urandom_range(0, 200);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) mem[bidx + i] = END_W;
                else        mem[bidx + i] = rand_word();
                if (r == 1) stall_cnt[bidx + i] = $urandom_range(1, 4);
            end
            mw = 16'($urandom_range(0, 12));
            model_run(32'(bidx * 4), mw);
            run_batch(32'(bidx * 4), mw, 1, 0);
        end

        // Reset in the middle of a held beat.
        chk_en = 0;
        clear_mem();
        mem[64] = 32'h1280_0005; mem[65] = 32'h2100_00AA;
        ready_mode = 2;
        @(posedge clock); #1;
        base_addr = 32'h100; max_words = 16'd8; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!beat_valid && n < 50) begin @(negedge clock); n++; end
        chk("rst_pre_valid", beat_valid, 1);
        d0 = done_total;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_bram", {bram_en, bram_we, bram_addr}, 64'd0);
        chk("rst_mid_din", bram_din, 0);
        chk("rst_mid_beat", {beat_valid, beat_feature, beat_class, beat_clause}, 64'd0);
        chk("rst_mid_stat", {busy, done, err_overrun, err_timeout, word_count}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        ready_mode = 0;
        repeat (5) @(posedge clock);
        #1;
        chk("rst_no_done", done_total - d0, 0);
        chk("rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
